// File: rtl/dbus_pkg.sv
// Shared definitions for the data-side bus router and its address decoder.
package dbus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_e;

  localparam int          NUM_TGT     = 2;
  localparam int          T_DMEM      = 0;
  localparam int          T_MMIO      = 1;
  localparam logic [31:0] T0_BASE     = 32'h0000_2000;
  localparam logic [31:0] T1_BASE     = 32'h0001_0000;
  localparam int          T0_SIZE_LG2 = 13;  // 8 KiB
  localparam int          T1_SIZE_LG2 = 12;  // 4 KiB
  localparam int          TIMEOUT     = 16;
  localparam int          CNT_W       = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dbus_req_t;

  // Partial stores may sit at any byte offset; loads and full-word stores must be word aligned.
  function automatic logic misaligned(input logic we, input logic [1:0] lsb, input logic [3:0] wstrb);
    return (lsb != 2'b00) && (!we || wstrb == 4'hF);
  endfunction
endpackage

// File: rtl/dbus_decode.sv
// Address decode to target hits; shared with the instruction-side bus.
module dbus_decode
  import dbus_pkg::*;
(
  input  logic [31:0] addr,
  output logic        hit0,
  output logic        hit1,
  output logic        fault
);
  assign hit0  = addr[31:T0_SIZE_LG2] == T0_BASE[31:T0_SIZE_LG2];
  assign hit1  = addr[31:T1_SIZE_LG2] == T1_BASE[31:T1_SIZE_LG2];
  assign fault = !(hit0 || hit1);
endmodule

// File: rtl/dbus_router.sv
// Data-side bus router: steers one CPU load/store to DMEM or MMIO and stalls until done.
module dbus_router
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        t0_req,
  output logic        t0_we,
  output logic [31:0] t0_addr,
  output logic [31:0] t0_wdata,
  output logic [3:0]  t0_wstrb,
  input  logic        t0_gnt,
  input  logic        t0_rvalid,
  input  logic [31:0] t0_rdata,
  output logic        t1_req,
  output logic        t1_we,
  output logic [31:0] t1_addr,
  output logic [31:0] t1_wdata,
  output logic [3:0]  t1_wstrb,
  input  logic        t1_gnt,
  input  logic        t1_rvalid,
  input  logic [31:0] t1_rdata
);
  state_e                        state;
  dbus_req_t                     lat;
  logic                          tgt;
  logic [CNT_W-1:0]              cnt;
  logic                          hit0, hit1, fault, bad, timeout;
  logic                          sel_gnt, sel_rv;
  logic [NUM_TGT-1:0]            gnt, rvalid;
  logic [NUM_TGT-1:0][31:0]      rdata;

  dbus_decode u_dec (.addr(cpu_addr), .hit0(hit0), .hit1(hit1), .fault(fault));

  assign gnt     = {t1_gnt, t0_gnt};
  assign rvalid  = {t1_rvalid, t0_rvalid};
  assign rdata   = {t1_rdata, t0_rdata};
  assign sel_gnt = gnt[tgt];
  assign sel_rv  = rvalid[tgt];
  assign bad     = fault || misaligned(cpu_we, cpu_addr[1:0], cpu_wstrb) ||
                   (cpu_we && cpu_wstrb == 4'h0);
  // Last allowed ISSUE/WAIT cycle; a completion in that cycle still wins.
  assign timeout = cnt == CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat       <= '0;
      tgt       <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_err <= 1'b0;
      case (state)
        S_IDLE: if (cpu_req) begin
          lat <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
          tgt <= hit1 && !hit0;
          cnt <= '0;
          if (bad) begin
            state     <= S_ERR;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if ((state == S_ISSUE && sel_gnt && (lat.we || sel_rv)) || (state == S_WAIT && sel_rv)) begin
            if (!lat.we) cpu_rdata <= rdata[tgt];
            state <= S_DONE;
          end else if (timeout) begin
            state     <= S_ERR;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            if (state == S_ISSUE && sel_gnt) state <= S_WAIT;
            if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cpu_stall = (state == S_IDLE && cpu_req) || state == S_ISSUE || state == S_WAIT;
  assign t0_req    = state == S_ISSUE && !tgt;
  assign t1_req    = state == S_ISSUE && tgt;
  assign t0_we     = lat.we;
  assign t0_addr   = lat.addr;
  assign t0_wdata  = lat.wdata;
  assign t0_wstrb  = lat.wstrb;
  assign t1_we     = lat.we;
  assign t1_addr   = lat.addr;
  assign t1_wdata  = lat.wdata;
  assign t1_wstrb  = lat.wstrb;
endmodule

// File: tb/tb_dbus_router.sv
// Randomized bench for dbus_router against a transaction-level timing model.
module tb_dbus_router;
  logic        clk = 1'b0, reset;
  logic        cpu_req, cpu_we, cpu_stall, cpu_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        t0_req, t0_we, t0_gnt, t0_rvalid, t1_req, t1_we, t1_gnt, t1_rvalid;
  logic [31:0] t0_addr, t0_wdata, t0_rdata, t1_addr, t1_wdata, t1_rdata;
  logic [3:0]  t0_wstrb, t1_wstrb;

  int errors = 0, checks = 0;

  dbus_router dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .t0_req(t0_req), .t0_we(t0_we), .t0_addr(t0_addr), .t0_wdata(t0_wdata),
    .t0_wstrb(t0_wstrb), .t0_gnt(t0_gnt), .t0_rvalid(t0_rvalid), .t0_rdata(t0_rdata),
    .t1_req(t1_req), .t1_we(t1_we), .t1_addr(t1_addr), .t1_wdata(t1_wdata), .t1_wstrb(t1_wstrb),
    .t1_gnt(t1_gnt), .t1_rvalid(t1_rvalid), .t1_rdata(t1_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_stall", cpu_stall, 0); chk("rst_err", cpu_err, 0); chk("rst_rdata", cpu_rdata, 0);
    chk("rst_t0_req", t0_req, 0);   chk("rst_t1_req", t1_req, 0);
    chk("rst_t0_we", t0_we, 0);     chk("rst_t0_addr", t0_addr, 0);
    chk("rst_t0_wdata", t0_wdata, 0); chk("rst_t0_wstrb", t0_wstrb, 0);
    chk("rst_t1_we", t1_we, 0);     chk("rst_t1_addr", t1_addr, 0);
    chk("rst_t1_wdata", t1_wdata, 0); chk("rst_t1_wstrb", t1_wstrb, 0);
  endtask

  // Idle cycles: no request, noisy targets, router must stay quiet.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_req = 1'b0; cpu_addr = $urandom; cpu_we = 1'($urandom);
      {t0_gnt, t0_rvalid, t1_gnt, t1_rvalid} = 4'($urandom);
      t0_rdata = $urandom; t1_rdata = $urandom;
      @(negedge clk);
      chk("idle_stall", cpu_stall, 0); chk("idle_t0_req", t0_req, 0);
      chk("idle_t1_req", t1_req, 0);   chk("idle_err", cpu_err, 0);
      @(posedge clk); #1;
    end
  endtask

  // One access. g = ISSUE cycles before the selected target grants, r = cycles from
  // grant to rvalid (0 = same cycle). Entered and left at posedge+1.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int g, input int r, input bit drop,
                         input logic [31:0] rv_data, output int n_stall, output int n_r0,
                         output int n_r1, output bit err_seen, output logic [31:0] rd_end);
    bit in0, in1, sel, bad, is_err, exp_req, gn, rv;
    int L, req_last;
    in0 = addr >= 32'h0000_2000 && addr < 32'h0000_4000;
    in1 = addr >= 32'h0001_0000 && addr < 32'h0001_1000;
    sel = in1;
    bad = !(in0 || in1) || (we && wstrb == 4'h0) || (addr[1:0] != 2'b00 && (!we || wstrb == 4'hF));
    if (bad) begin
      L = 1; req_last = 0; is_err = 1'b1;
    end else begin
      req_last = (g + 1 < 16) ? g + 1 : 16;
      is_err   = we ? (g > 15) : (g + r > 15);
      L        = is_err ? 17 : (we ? g + 2 : g + r + 2);
    end
    n_stall = 0; n_r0 = 0; n_r1 = 0; err_seen = 1'b0; rd_end = 'x;
    for (int t = 0; t <= L; t++) begin
      cpu_req = (t == 0) || (!drop && t < L);
      if (t == 0) begin
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
      end else begin
        cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
      end
      {t0_gnt, t0_rvalid, t1_gnt, t1_rvalid} = 4'($urandom);
      t0_rdata = $urandom; t1_rdata = $urandom;
      if (!bad) begin
        gn = (t == 1 + g);
        rv = !we && (t == 1 + g + r);
        if (sel) begin t1_gnt = gn; t1_rvalid = rv; if (rv) t1_rdata = rv_data; end
        else     begin t0_gnt = gn; t0_rvalid = rv; if (rv) t0_rdata = rv_data; end
      end
      @(negedge clk);
      exp_req = !bad && t >= 1 && t <= req_last;
      chk("stall", cpu_stall, t < L);
      chk("t0_req", t0_req, exp_req && !sel);
      chk("t1_req", t1_req, exp_req && sel);
      chk("cpu_err", cpu_err, is_err && t == L);
      if (exp_req) begin
        chk("tgt_we",    sel ? t1_we : t0_we, we);
        chk("tgt_addr",  sel ? t1_addr : t0_addr, addr);
        chk("tgt_wdata", sel ? t1_wdata : t0_wdata, wdata);
        chk("tgt_wstrb", sel ? t1_wstrb : t0_wstrb, wstrb);
      end
      if (t == L && (is_err || !we)) chk("cpu_rdata", cpu_rdata, is_err ? 32'h0 : rv_data);
      n_stall += int'(cpu_stall); n_r0 += int'(t0_req); n_r1 += int'(t1_req);
      err_seen |= cpu_err;
      if (t == L) rd_end = cpu_rdata;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 9);
    if (k < 4)      a = 32'h0000_2000 + 32'($urandom_range(0, 8191));
    else if (k < 7) a = 32'h0001_0000 + 32'($urandom_range(0, 4095));
    else begin
      case ($urandom_range(0, 6))
        0: a = 32'h0000_0000; 1: a = 32'h0000_0100; 2: a = 32'h0000_1FFC;
        3: a = 32'h0000_4000; 4: a = 32'h0000_FFFC; 5: a = 32'h0001_1000;
        default: a = 32'h8000_2000;
      endcase
    end
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic logic [3:0] rand_strb();
    case ($urandom_range(0, 9))
      0: return 4'h1; 1: return 4'h2; 2: return 4'h4; 3: return 4'h8;
      4: return 4'h3; 5: return 4'hC; 6: return 4'h0;
      default: return 4'hF;
    endcase
  endfunction

  initial begin
    int ns, n0, n1;
    bit es;
    logic [31:0] rd;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    t0_gnt = 0; t0_rvalid = 0; t0_rdata = 0; t1_gnt = 0; t1_rvalid = 0; t1_rdata = 0;
    #1 chk_reset_vals();
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    idle(2);

    // Store, grant immediate: one request cycle, two stall cycles
    run_txn(1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, ns, n0, n1, es, rd);
    chk("st_stall_cnt", ns, 2); chk("st_t0_req_cnt", n0, 1); chk("st_t1_req_cnt", n1, 0);
    chk("st_err", es, 0);

    // MMIO load, grant in third ISSUE cycle, rvalid three cycles later
    run_txn(0, 32'h0001_0010, 32'h0, 4'h0, 2, 3, 0, 32'h0000_00A5, ns, n0, n1, es, rd);
    chk("ld_stall_cnt", ns, 7); chk("ld_rdata", rd, 32'h0000_00A5);
    chk("ld_t1_req_cnt", n1, 3); chk("ld_t0_req_cnt", n0, 0);

    // Reset while waiting for rvalid
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_2000; t0_gnt = 0; t1_gnt = 0; t0_rvalid = 0; t1_rvalid = 0;
    @(posedge clk); #1 t0_gnt = 1;
    @(posedge clk); #1 t0_gnt = 0;
    #2 chk("wait_stall", cpu_stall, 1); chk("wait_t0_req", t0_req, 0);
    cpu_req = 0; reset = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 32'h0000_2008, 32'h0, 4'h0, 0, 1, 0, 32'h1234_5678, ns, n0, n1, es, rd);
    chk("post_rst_rdata", rd, 32'h1234_5678); chk("min_ld_stall_cnt", ns, 3);

    // Unmapped load faults without touching a target
    run_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, ns, n0, n1, es, rd);
    chk("unm_err", es, 1); chk("unm_rdata", rd, 0); chk("unm_reqs", n0 + n1, 0); chk("unm_stall_cnt", ns, 1);

    // Misaligned load faults; misaligned byte store is legal
    run_txn(0, 32'h0000_2002, 32'h0, 4'h0, 0, 0, 0, 0, ns, n0, n1, es, rd);
    chk("mis_err", es, 1);
    run_txn(1, 32'h0000_2003, 32'hAA00_0000, 4'h8, 0, 0, 0, 0, ns, n0, n1, es, rd);
    chk("byte_st_err", es, 0); chk("byte_st_stall_cnt", ns, 2);

    // Grant never arrives: request drops after TIMEOUT cycles
    run_txn(1, 32'h0000_2000, 32'h5555_5555, 4'hF, 40, 0, 1, 0, ns, n0, n1, es, rd);
    chk("to_t0_req_cnt", n0, 16); chk("to_err", es, 1); chk("to_stall_cnt", ns, 17);

    // Load on t0 with noise on t1 throughout
    run_txn(0, 32'h0000_3FFC, 32'h0, 4'h0, 1, 4, 0, 32'hCAFE_F00D, ns, n0, n1, es, rd);
    chk("noise_rdata", rd, 32'hCAFE_F00D); chk("noise_t1_req_cnt", n1, 0);

    for (int i = 0; i < 300; i++) begin
      logic        we;
      int          g, r;
      we = 1'($urandom);
      g  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 19)) : int'($urandom_range(0, 3));
      r  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 14))  : int'($urandom_range(0, 3));
      run_txn(we, rand_addr(), $urandom, rand_strb(), g, r, 1'($urandom), $urandom, ns, n0, n1, es, rd);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
